// File: rtl/fetch_unit.sv
// Instruction fetch unit: REQ/WAIT/HOLD handshake with instruction memory, redirect handling.
// Optional misaligned-redirect detection is enabled by defining FETCH_ALIGN_CHECK_EN.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic [31:0] Instr,
    output logic [5:0]  Opcode,
    output logic [31:0] PCPlus4,
`ifdef FETCH_ALIGN_CHECK_EN
    output logic        addr_misaligned,
`endif
    output logic        instr_valid
);

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] pcplus4_q, pcplus4_d;
    logic        discard_q, discard_d;

    logic        redirect_take;
    logic [31:0] redirect_target;
    logic [31:0] pc_inc;

    // Natural 32-bit overflow gives the required wrap from FFFF_FFFC to 0.
    assign pc_inc = pc_q + 32'd4;

`ifdef FETCH_ALIGN_CHECK_EN
    logic misaligned_q;

    // A misaligned redirect is dropped entirely; fetch carries on at the current PC.
    assign redirect_take   = redirect_valid && (redirect_pc[1:0] == 2'b00);
    assign redirect_target = redirect_pc;

    always_ff @(posedge clk) begin
        if (reset) begin
            misaligned_q <= 1'b0;
        end else if (redirect_valid && (redirect_pc[1:0] != 2'b00)) begin
            misaligned_q <= 1'b1;
        end
    end

    assign addr_misaligned = misaligned_q;
`else
    assign redirect_take   = redirect_valid;
    assign redirect_target = {redirect_pc[31:2], 2'b00};
`endif

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_REQ;
            pc_q      <= RESET_PC;
            instr_q   <= '0;
            pcplus4_q <= '0;
            discard_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            instr_q   <= instr_d;
            pcplus4_q <= pcplus4_d;
            discard_q <= discard_d;
        end
    end

    // NOTE: every signal gets its hold value first so no path through the case infers a latch.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        instr_d   = instr_q;
        pcplus4_d = pcplus4_q;
        discard_d = discard_q;

        unique case (state_q)
            S_REQ: begin
                if (redirect_take) begin
                    pc_d = redirect_target;
                    // A grant in the redirect cycle leaves a response in flight that must be dropped.
                    if (imem_gnt) begin
                        state_d   = S_WAIT;
                        discard_d = 1'b1;
                    end
                end else if (imem_gnt) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (redirect_take) begin
                    pc_d = redirect_target;
                    // The in-flight response is either arriving now (drop it) or still to come.
                    if (imem_rvalid) begin
                        state_d   = S_REQ;
                        discard_d = 1'b0;
                    end else begin
                        discard_d = 1'b1;
                    end
                end else if (imem_rvalid) begin
                    if (discard_q) begin
                        state_d   = S_REQ;
                        discard_d = 1'b0;
                    end else begin
                        instr_d   = imem_rdata;
                        pcplus4_d = pc_inc;
                        pc_d      = pc_inc;
                        state_d   = S_HOLD;
                    end
                end
            end
            S_HOLD: begin
                if (redirect_take) begin
                    pc_d    = redirect_target;
                    state_d = S_REQ;
                end else if (!stall) begin
                    state_d = S_REQ;
                end
            end
            default: begin
                state_d = S_REQ;
            end
        endcase
    end

    assign imem_req    = (state_q == S_REQ) && !reset;
    assign imem_addr   = pc_q;
    assign instr_valid = (state_q == S_HOLD) && !reset;
    assign Instr       = instr_q;
    assign Opcode      = instr_q[31:26];
    assign PCPlus4     = pcplus4_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit; optional FETCH_ALIGN_CHECK_EN checks included.
module tb_fetch_unit;

    logic        clk;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [31:0] Instr;
    logic [5:0]  Opcode;
    logic [31:0] PCPlus4;
    logic        instr_valid;
`ifdef FETCH_ALIGN_CHECK_EN
    logic        addr_misaligned;
`endif

    int          checks;
    int          errors;
    logic [31:0] last_instr;

    fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
        .clk            (clk),
        .reset          (reset),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_gnt       (imem_gnt),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .Instr          (Instr),
        .Opcode         (Opcode),
        .PCPlus4        (PCPlus4),
`ifdef FETCH_ALIGN_CHECK_EN
        .addr_misaligned(addr_misaligned),
`endif
        .instr_valid    (instr_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Fetch one word from REQ at 'addr'; ends one cycle after the response, in HOLD.
    task automatic test_fetch(input logic [31:0] addr, input logic [31:0] data,
                              input int gnt_wait, input int rv_wait);
        logic [5:0]  exp_op;
        logic [31:0] exp_p4;
        exp_op = data[31:26];
        exp_p4 = addr + 32'd4;
        for (int i = 0; i < gnt_wait; i++) step();
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== addr) begin
            errors++;
            $display("FAIL fetch_req: req=%b addr=%h, want req=1 addr=%h", imem_req, imem_addr, addr);
        end
        imem_gnt = 1'b1;
        step();
        imem_gnt = 1'b0;
        checks++;
        if (imem_req !== 1'b0 || instr_valid !== 1'b0) begin
            errors++;
            $display("FAIL fetch_wait: req=%b valid=%b, want 0 0", imem_req, instr_valid);
        end
        for (int i = 0; i < rv_wait; i++) step();
        imem_rvalid = 1'b1;
        imem_rdata  = data;
        step();
        imem_rvalid = 1'b0;
        imem_rdata  = 32'h0;
        checks++;
        if (instr_valid !== 1'b1 || Instr !== data || Opcode !== exp_op ||
            PCPlus4 !== exp_p4 || imem_req !== 1'b0) begin
            errors++;
            $display("FAIL fetch_hold: valid=%b instr=%h op=%b p4=%h req=%b, want 1 %h %b %h 0",
                     instr_valid, Instr, Opcode, PCPlus4, imem_req, data, exp_op, exp_p4);
        end
        last_instr = data;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step();
        step();
        checks++;
        if (imem_req !== 1'b0 || instr_valid !== 1'b0 || Instr !== 32'h0 ||
            PCPlus4 !== 32'h0 || imem_addr !== 32'h0) begin
            errors++;
            $display("FAIL reset_state: req=%b valid=%b instr=%h p4=%h addr=%h, want 0 0 0 0 0",
                     imem_req, instr_valid, Instr, PCPlus4, imem_addr);
        end
`ifdef FETCH_ALIGN_CHECK_EN
        checks++;
        if (addr_misaligned !== 1'b0) begin
            errors++;
            $display("FAIL reset_misaligned: got %b want 0", addr_misaligned);
        end
`endif
        reset = 1'b0;
        #1;
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
            errors++;
            $display("FAIL reset_release: req=%b addr=%h, want 1 00000000", imem_req, imem_addr);
        end
    endtask

    task automatic test_basic();
        stall = 1'b1;
        test_fetch(32'h0, 32'h8C08_0004, 0, 0);
        checks++;
        if (Opcode !== 6'b100011 || PCPlus4 !== 32'h4) begin
            errors++;
            $display("FAIL basic_decode: op=%b p4=%h, want 100011 00000004", Opcode, PCPlus4);
        end
    endtask

    task automatic test_stall();
        for (int i = 0; i < 5; i++) begin
            if (i == 2) begin
                imem_rvalid = 1'b1;
                imem_rdata  = 32'hFFFF_FFFF;
            end
            step();
            imem_rvalid = 1'b0;
            checks++;
            if (instr_valid !== 1'b1 || Instr !== 32'h8C08_0004 ||
                PCPlus4 !== 32'h4 || imem_req !== 1'b0) begin
                errors++;
                $display("FAIL stall_hold[%0d]: valid=%b instr=%h p4=%h req=%b, want 1 8c080004 4 0",
                         i, instr_valid, Instr, PCPlus4, imem_req);
            end
        end
        stall = 1'b0;
        step();
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h4 || instr_valid !== 1'b0) begin
            errors++;
            $display("FAIL stall_release: req=%b addr=%h valid=%b, want 1 4 0", imem_req, imem_addr, instr_valid);
        end
    endtask

    task automatic test_back_to_back();
        stall = 1'b0;
        test_fetch(32'h4, 32'h2002_0005, 2, 2);
        step();
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h8 || instr_valid !== 1'b0) begin
            errors++;
            $display("FAIL b2b_next: req=%b addr=%h valid=%b, want 1 8 0", imem_req, imem_addr, instr_valid);
        end
    endtask

    task automatic test_redirect_wait();
        imem_gnt = 1'b1;
        step();
        imem_gnt       = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h40;
        step();
        redirect_valid = 1'b0;
        checks++;
        if (imem_req !== 1'b0 || instr_valid !== 1'b0) begin
            errors++;
            $display("FAIL redir_wait_hold: req=%b valid=%b, want 0 0", imem_req, instr_valid);
        end
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hDEAD_BEEF;
        step();
        imem_rvalid = 1'b0;
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h40 || instr_valid !== 1'b0 || Instr !== last_instr) begin
            errors++;
            $display("FAIL redir_wait_drop: req=%b addr=%h valid=%b instr=%h, want 1 40 0 %h",
                     imem_req, imem_addr, instr_valid, Instr, last_instr);
        end
    endtask

    task automatic test_redirect_rvalid();
        imem_gnt = 1'b1;
        step();
        imem_gnt       = 1'b0;
        imem_rvalid    = 1'b1;
        imem_rdata     = 32'hCAFE_0001;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h80;
        step();
        redirect_valid = 1'b0;
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h80 || instr_valid !== 1'b0) begin
            errors++;
            $display("FAIL redir_rvalid: req=%b addr=%h valid=%b, want 1 80 0", imem_req, imem_addr, instr_valid);
        end
        step();
        imem_rvalid = 1'b0;
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h80 || instr_valid !== 1'b0 || Instr !== last_instr) begin
            errors++;
            $display("FAIL stray_rvalid: req=%b addr=%h valid=%b instr=%h, want 1 80 0 %h",
                     imem_req, imem_addr, instr_valid, Instr, last_instr);
        end
    endtask

    task automatic test_redirect_req();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h100;
        step();
        redirect_valid = 1'b0;
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h100) begin
            errors++;
            $display("FAIL redir_req: req=%b addr=%h, want 1 100", imem_req, imem_addr);
        end
    endtask

    task automatic test_redirect_grant();
        imem_gnt       = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h200;
        step();
        imem_gnt       = 1'b0;
        redirect_valid = 1'b0;
        checks++;
        if (imem_req !== 1'b0 || instr_valid !== 1'b0) begin
            errors++;
            $display("FAIL redir_gnt_wait: req=%b valid=%b, want 0 0", imem_req, instr_valid);
        end
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hBAD0_0BAD;
        step();
        imem_rvalid = 1'b0;
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h200 || instr_valid !== 1'b0 || Instr !== last_instr) begin
            errors++;
            $display("FAIL redir_gnt_drop: req=%b addr=%h valid=%b instr=%h, want 1 200 0 %h",
                     imem_req, imem_addr, instr_valid, Instr, last_instr);
        end
        stall = 1'b1;
        test_fetch(32'h200, 32'h0043_2020, 0, 1);
    endtask

    task automatic test_redirect_hold();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h300;
        step();
        redirect_valid = 1'b0;
        checks++;
        if (instr_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h300) begin
            errors++;
            $display("FAIL redir_hold_stall: valid=%b req=%b addr=%h, want 0 1 300", instr_valid, imem_req, imem_addr);
        end
        stall = 1'b0;
        test_fetch(32'h300, 32'h1000_FFFF, 0, 0);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h400;
        step();
        redirect_valid = 1'b0;
        checks++;
        if (instr_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h400) begin
            errors++;
            $display("FAIL redir_consume: valid=%b req=%b addr=%h, want 0 1 400", instr_valid, imem_req, imem_addr);
        end
    endtask

    task automatic test_align();
`ifdef FETCH_ALIGN_CHECK_EN
        redirect_valid = 1'b1;
        redirect_pc    = 32'h42;
        step();
        redirect_valid = 1'b0;
        checks++;
        if (addr_misaligned !== 1'b1 || imem_req !== 1'b1 || imem_addr !== 32'h400) begin
            errors++;
            $display("FAIL align_flag: mis=%b req=%b addr=%h, want 1 1 400", addr_misaligned, imem_req, imem_addr);
        end
        step();
        checks++;
        if (addr_misaligned !== 1'b1) begin
            errors++;
            $display("FAIL align_sticky: mis=%b, want 1", addr_misaligned);
        end
`else
        redirect_valid = 1'b1;
        redirect_pc    = 32'h542;
        step();
        redirect_valid = 1'b0;
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h540) begin
            errors++;
            $display("FAIL align_force: req=%b addr=%h, want 1 540", imem_req, imem_addr);
        end
`endif
    endtask

    task automatic test_wrap();
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFC;
        step();
        redirect_valid = 1'b0;
        stall = 1'b0;
        test_fetch(32'hFFFF_FFFC, 32'h0800_0000, 1, 0);
        checks++;
        if (PCPlus4 !== 32'h0) begin
            errors++;
            $display("FAIL wrap_p4: p4=%h, want 00000000", PCPlus4);
        end
        step();
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h0 || instr_valid !== 1'b0) begin
            errors++;
            $display("FAIL wrap_next: req=%b addr=%h valid=%b, want 1 0 0", imem_req, imem_addr, instr_valid);
        end
    endtask

    task automatic test_reset_mid();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h80;
        step();
        redirect_valid = 1'b0;
        imem_gnt = 1'b1;
        step();
        imem_gnt = 1'b0;
        reset    = 1'b1;
        step();
        checks++;
        if (imem_req !== 1'b0 || instr_valid !== 1'b0 || Instr !== 32'h0 ||
            PCPlus4 !== 32'h0 || imem_addr !== 32'h0) begin
            errors++;
            $display("FAIL reset_mid: req=%b valid=%b instr=%h p4=%h addr=%h, want 0 0 0 0 0",
                     imem_req, instr_valid, Instr, PCPlus4, imem_addr);
        end
`ifdef FETCH_ALIGN_CHECK_EN
        checks++;
        if (addr_misaligned !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_mis: mis=%b, want 0", addr_misaligned);
        end
`endif
        reset = 1'b0;
        #1;
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
            errors++;
            $display("FAIL reset_mid_release: req=%b addr=%h, want 1 0", imem_req, imem_addr);
        end
    endtask

    initial begin
        checks         = 0;
        errors         = 0;
        last_instr     = 32'h0;
        reset          = 1'b1;
        imem_gnt       = 1'b0;
        imem_rvalid    = 1'b0;
        imem_rdata     = 32'h0;
        stall          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        @(negedge clk);
        test_reset();
        test_basic();
        test_stall();
        test_back_to_back();
        test_redirect_wait();
        test_redirect_rvalid();
        test_redirect_req();
        test_redirect_grant();
        test_redirect_hold();
        test_align();
        test_wrap();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter: RESET_PC, 32'h0000_0000, first fetch address after reset.
REQ-002 Port: clk  in  1  sole clock; all state SHALL update on its rising edge.
REQ-003 Port: reset  in  1  synchronous, active-high reset.
REQ-004 Port: imem_req  out  1  fetch request to instruction memory.
REQ-005 Port: imem_addr  out  32  word address of the request.
REQ-006 Port: imem_gnt  in  1  request accepted; handshake completes when imem_req & imem_gnt.
REQ-007 Port: imem_rvalid  in  1  read data valid, at least 1 cycle after grant.
REQ-008 Port: imem_rdata  in  32  returned instruction word.
REQ-009 Port: stall  in  1  decode stage cannot accept the held instruction.
REQ-010 Port: redirect_valid  in  1  one-cycle pulse for a taken branch or jump.
REQ-011 Port: redirect_pc  in  32  new fetch PC when redirect_valid=1.
REQ-012 Port: Instr  out  32  held instruction.
REQ-013 Port: Opcode  out  6  Instr[31:26], feeds the main decoder.
REQ-014 Port: PCPlus4  out  32  address of Instr + 4.
REQ-015 Port: instr_valid  out  1  Instr/Opcode/PCPlus4 are valid.

Function
REQ-016 States SHALL be REQ (imem_req=1), WAIT (granted, awaiting rvalid) and HOLD (instr_valid=1).
REQ-017 REQ->WAIT on imem_gnt; WAIT->HOLD on imem_rvalid with discard=0; HOLD->REQ when instr_valid & !stall (consume).
REQ-018 imem_addr SHALL equal the PC register; at most one request SHALL be outstanding.
REQ-019 On an accepted response, Instr<=imem_rdata, PCPlus4<=PC+4, PC<=PC+4, and instr_valid=1 from the next cycle.
REQ-020 Instr, Opcode and PCPlus4 SHALL stay stable while instr_valid=1 and stall=1.
REQ-021 PC+4 SHALL wrap modulo 2^32 (32'hFFFF_FFFC -> 32'h0000_0000).
REQ-022 redirect_valid SHALL take priority over all other events in every state: PC<=redirect_pc and instr_valid=0 next cycle.
REQ-023 Redirect in REQ without grant: request withdrawn, next cycle REQ at redirect_pc; ungranted address change is permitted.
REQ-024 Redirect in REQ with grant in the same cycle, or in WAIT: discard<=1 and state WAIT; the next rvalid SHALL be dropped, then discard<=0 and REQ at redirect_pc.
REQ-025 Redirect coinciding with rvalid (discard=0): the response SHALL be dropped, state REQ at redirect_pc.
REQ-026 Redirect in HOLD, with or without stall or consume: the held instruction SHALL be dropped, state REQ next cycle.
REQ-027 imem_rvalid outside WAIT SHALL be ignored.

Reset
REQ-028 While reset=1: state=REQ, PC=RESET_PC, discard=0, instr_valid=0, Instr=0, PCPlus4=0, imem_req=0.
REQ-029 First cycle after reset deasserts: imem_req=1 and imem_addr=RESET_PC.
REQ-030 Reset mid-operation SHALL abandon any outstanding request; instruction memory shares this reset, so no stale response is expected.

Configuration
REQ-031 Macro FETCH_ALIGN_CHECK_EN SHALL gate misalignment checking.
REQ-032 With FETCH_ALIGN_CHECK_EN defined: output addr_misaligned (1 bit) SHALL be present; a redirect with redirect_pc[1:0]!=0 sets it sticky until reset; that redirect SHALL be ignored; fetch continues at the old PC.
REQ-033 Without FETCH_ALIGN_CHECK_EN: no addr_misaligned port; redirect_pc[1:0] SHALL be forced to 2'b00.

Verification
REQ-034 Reset release, gnt=1, rvalid 1 cycle later with rdata=32'h8C08_0004 -> addr 0, instr_valid=1, Opcode=6'b100011, PCPlus4=4.
REQ-035 stall=1 for 5 cycles in HOLD -> Instr stable, imem_req=0; stall drops -> next request at addr 4.
REQ-036 Redirect to 32'h0000_0040 while in WAIT at addr 8 -> rdata of addr 8 never appears; next request addr 32'h40.
REQ-037 PC=32'hFFFF_FFFC, fetch completes -> PCPlus4=0, next imem_addr=0.
REQ-038 Redirect in the same cycle as consume in HOLD -> instr_valid=0 next cycle, next request at redirect_pc.
REQ-039 With FETCH_ALIGN_CHECK_EN: redirect to 32'h0000_0042 -> addr_misaligned=1 and the PC is unchanged.
